// File: rtl/aes2_seq_pkg.sv
// Shared types and constants for the AES2 register-bus sequencer: FSM states,
// the AES2 register map offsets and the response error codes.
package aes2_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_KEY,
    ST_WR_DIN,
    ST_WR_START,
    ST_POLL,
    ST_RD_DOUT,
    ST_RESP
  } state_e;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_KEY    = 8'h10;
  localparam logic [7:0] REG_DIN    = 8'h20;
  localparam logic [7:0] REG_DOUT   = 8'h30;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_BUS = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  localparam logic [31:0] AES2_BASE_DEFAULT = 32'h1010_0000;
  localparam logic [31:0] CMD_START         = 32'h0000_0001;
  localparam logic [3:0]  WSTRB_ALL         = 4'hF;

  // Byte offset of word idx (0..3) inside a four-word register group.
  function automatic logic [7:0] word_offset(input logic [7:0] group, input logic [1:0] idx);
    return group + {4'h0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/aes2_seq_bus_master.sv
// Single-beat register-bus master: presents the request while req_i is high and
// returns a one-cycle done/err pulse with the read data when the slave completes it.
module aes2_seq_bus_master
  import aes2_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_write_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]            bus_wstrb_o,
  output logic                  bus_valid_o,
  input  logic                  bus_ready_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_error_i
);

  // The caller holds req/addr/data constant until done_o, so the request is
  // forwarded combinationally; this keeps back-to-back beats free of bubbles.
  assign bus_valid_o = req_i;
  assign bus_addr_o  = addr_i;
  assign bus_write_o = write_i;
  assign bus_wdata_o = wdata_i;
  assign bus_wstrb_o = WSTRB_ALL;

  assign done_o  = req_i & bus_ready_i;
  assign err_o   = done_o & bus_error_i;
  assign rdata_o = bus_rdata_i;

endmodule

// File: rtl/aes2_reg_sequencer.sv
// Runs one AES2 block operation end to end: key/din writes, start, status poll,
// result read-back. Optional key cache selected by AES2_SEQ_KEY_CACHE_EN.
module aes2_reg_sequencer
  import aes2_seq_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(AES2_BASE_DEFAULT),
  parameter int unsigned           TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [127:0]          job_key_i,
  input  logic [127:0]          job_din_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [127:0]          resp_dout_o,
  output logic [1:0]            resp_err_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic                  bus_write_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]            bus_wstrb_o,
  output logic                  bus_valid_o,
  input  logic                  bus_ready_i,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_error_i
);

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  logic [1:0]         word_q, word_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [127:0]       dout_q, dout_d;
  logic [1:0]         err_q, err_d;
  logic [127:0]       key_q, din_q;

  logic                  req, req_write;
  logic [7:0]            req_off;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  beat_done, beat_err;
  logic [DATA_WIDTH-1:0] beat_rdata;
  logic                  accept, key_hit;

  assign accept   = (state_q == ST_IDLE) && job_valid_i;
  assign req_addr = BASE_ADDR + ADDR_WIDTH'(req_off);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    word_d    = word_q;
    tmo_d     = tmo_q;
    dout_d    = dout_q;
    err_d     = err_q;
    req       = 1'b0;
    req_write = 1'b0;
    req_off   = REG_CTRL;
    req_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (job_valid_i) begin
          state_d = key_hit ? ST_WR_DIN : ST_WR_KEY;
          dout_d  = '0;
          err_d   = ERR_OK;
        end
      end
      ST_WR_KEY: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_off   = word_offset(REG_KEY, word_q);
        req_wdata = key_q[{word_q, 5'd0} +: 32];
        if (beat_done) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = ST_WR_DIN;
        end
      end
      ST_WR_DIN: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_off   = word_offset(REG_DIN, word_q);
        req_wdata = din_q[{word_q, 5'd0} +: 32];
        if (beat_done) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = ST_WR_START;
        end
      end
      ST_WR_START: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_off   = REG_CTRL;
        req_wdata = CMD_START;
        if (beat_done) state_d = ST_POLL;
      end
      ST_POLL: begin
        req     = 1'b1;
        req_off = REG_STATUS;
        tmo_d   = tmo_q + 1'b1;
        // A done read in the final timeout cycle still wins over the timeout.
        if (beat_done && beat_rdata[0]) begin
          state_d = ST_RD_DOUT;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_RESP;
          err_d   = ERR_TMO;
          dout_d  = '0;
        end
      end
      ST_RD_DOUT: begin
        req     = 1'b1;
        req_off = word_offset(REG_DOUT, word_q);
        if (beat_done) begin
          dout_d[{word_q, 5'd0} +: 32] = beat_rdata;
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (beat_err) begin
      state_d = ST_RESP;
      err_d   = ERR_BUS;
      dout_d  = '0;
    end
    if (state_d != state_q) word_d = '0;
    if ((state_d == ST_POLL) && (state_q != ST_POLL)) tmo_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      tmo_q   <= '0;
      dout_q  <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // NOTE: job operands are pure datapath captured on accept and never read
  // before that, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      key_q <= job_key_i;
      din_q <= job_din_i;
    end
  end

`ifdef AES2_SEQ_KEY_CACHE_EN
  logic [127:0] cache_key_q;
  logic         key_valid_q;
  logic         enter_resp;

  assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);
  assign key_hit    = key_valid_q && (job_key_i == cache_key_q);

  // The cache is trusted only after a clean completion; any error invalidates it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         key_valid_q <= 1'b0;
    else if (enter_resp) key_valid_q <= (err_d == ERR_OK);
  end

  always_ff @(posedge clk_i) begin
    if (enter_resp && (err_d == ERR_OK)) cache_key_q <= key_q;
  end
`else
  assign key_hit = 1'b0;
`endif

  aes2_seq_bus_master #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bus_master (
    .req_i       (req),
    .addr_i      (req_addr),
    .write_i     (req_write),
    .wdata_i     (req_wdata),
    .done_o      (beat_done),
    .err_o       (beat_err),
    .rdata_o     (beat_rdata),
    .bus_addr_o  (bus_addr_o),
    .bus_write_o (bus_write_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_wstrb_o (bus_wstrb_o),
    .bus_valid_o (bus_valid_o),
    .bus_ready_i (bus_ready_i),
    .bus_rdata_i (bus_rdata_i),
    .bus_error_i (bus_error_i)
  );

  // Ready is gated by reset so every handshake output reads low while held in reset.
  assign job_ready_o  = (state_q == ST_IDLE) && rst_ni;
  assign busy_o       = (state_q != ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_dout_o  = dout_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_aes2_reg_sequencer.sv
// Directed bench for aes2_reg_sequencer with a register-level AES2 slave model;
// the key-cache scenario runs only when AES2_SEQ_KEY_CACHE_EN is defined.
module tb_aes2_reg_sequencer;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h04;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         job_valid_i = 1'b0;
  logic         job_ready_o;
  logic [127:0] job_key_i = '0;
  logic [127:0] job_din_i = '0;
  logic         resp_valid_o;
  logic         resp_ready_i = 1'b0;
  logic [127:0] resp_dout_o;
  logic [1:0]   resp_err_o;
  logic         busy_o;
  logic [31:0]  bus_addr_o;
  logic         bus_write_o;
  logic [31:0]  bus_wdata_o;
  logic [3:0]   bus_wstrb_o;
  logic         bus_valid_o;
  logic         bus_ready_i;
  logic [31:0]  bus_rdata_i;
  logic         bus_error_i;

  // Second instance with a short timeout, driven by an always-ready, never-done slave.
  logic         t_job_valid = 1'b0;
  logic         t_job_ready, t_resp_valid, t_busy, t_bus_write, t_bus_valid;
  logic         t_resp_ready = 1'b0;
  logic [127:0] t_resp_dout;
  logic [1:0]   t_resp_err;
  logic [31:0]  t_bus_addr, t_bus_wdata;
  logic [3:0]   t_bus_wstrb;

  int n_assert = 0;
  int n_fail   = 0;

  aes2_reg_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .TIMEOUT_CYC(1024)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_key_i(job_key_i), .job_din_i(job_din_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_dout_o(resp_dout_o), .resp_err_o(resp_err_o), .busy_o(busy_o),
    .bus_addr_o(bus_addr_o), .bus_write_o(bus_write_o), .bus_wdata_o(bus_wdata_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
    .bus_rdata_i(bus_rdata_i), .bus_error_i(bus_error_i)
  );

  aes2_reg_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .TIMEOUT_CYC(16)) dut_tmo (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_valid_i(t_job_valid), .job_ready_o(t_job_ready),
    .job_key_i(128'h1111_2222_3333_4444_5555_6666_7777_8888), .job_din_i(128'h0),
    .resp_valid_o(t_resp_valid), .resp_ready_i(t_resp_ready),
    .resp_dout_o(t_resp_dout), .resp_err_o(t_resp_err), .busy_o(t_busy),
    .bus_addr_o(t_bus_addr), .bus_write_o(t_bus_write), .bus_wdata_o(t_bus_wdata),
    .bus_wstrb_o(t_bus_wstrb), .bus_valid_o(t_bus_valid), .bus_ready_i(1'b1),
    .bus_rdata_i(32'h0), .bus_error_i(1'b0)
  );

  // ---------------- AES2 slave model ----------------
  int          wait_cfg = 0;
  int          done_on_poll = 1;   // 0: never report done
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic        model_clr = 1'b0;

  int          wcnt = 0;
  int          poll_cnt = 0;
  int          stab_err = 0;
  logic [31:0] s_key [4];
  logic [31:0] s_din [4];
  logic [31:0] s_res [4];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic        prev_write = 1'b0;
  logic [31:0] log_addr [$];
  logic        log_wr [$];
  logic [31:0] log_wd [$];

  function automatic logic [127:0] exp_res(input logic [127:0] k, input logic [127:0] d);
    logic [127:0] r;
    logic [31:0]  dw;
    for (int i = 0; i < 4; i++) begin
      dw = d[32*i +: 32];
      r[32*i +: 32] = k[32*i +: 32] ^ {dw[15:0], dw[31:16]};
    end
    return r;
  endfunction

  always @* begin
    bus_ready_i = bus_valid_o && (wcnt == wait_cfg);
    bus_error_i = err_en && (bus_addr_o == err_addr);
    bus_rdata_i = '0;
    if (bus_addr_o == A_STAT)
      bus_rdata_i[0] = (done_on_poll != 0) && (poll_cnt + 1 >= done_on_poll);
    else if (bus_addr_o >= BASE + 32'h30 && bus_addr_o <= BASE + 32'h3C)
      bus_rdata_i = s_res[bus_addr_o[3:2]];
  end

  always @(posedge clk_i) begin
    if (model_clr) begin
      poll_cnt <= 0;
      stab_err <= 0;
      log_addr.delete();
      log_wr.delete();
      log_wd.delete();
    end
    if (!rst_ni) begin
      wcnt      <= 0;
      prev_wait <= 1'b0;
    end else begin
      if (prev_wait && bus_valid_o &&
          (bus_addr_o !== prev_addr || bus_write_o !== prev_write || bus_wdata_o !== prev_wdata))
        stab_err <= stab_err + 1;
      if (bus_valid_o && bus_ready_i) begin
        wcnt <= 0;
        log_addr.push_back(bus_addr_o);
        log_wr.push_back(bus_write_o);
        log_wd.push_back(bus_wdata_o);
        if (bus_write_o && !bus_error_i) begin
          if (bus_addr_o >= BASE + 32'h10 && bus_addr_o <= BASE + 32'h1C) s_key[bus_addr_o[3:2]] <= bus_wdata_o;
          if (bus_addr_o >= BASE + 32'h20 && bus_addr_o <= BASE + 32'h2C) s_din[bus_addr_o[3:2]] <= bus_wdata_o;
          if (bus_addr_o == A_CTRL && bus_wdata_o[0])
            for (int i = 0; i < 4; i++) s_res[i] <= s_key[i] ^ {s_din[i][15:0], s_din[i][31:16]};
        end else if (!bus_write_o && bus_addr_o == A_STAT) begin
          poll_cnt <= poll_cnt + 1;
        end
      end else if (bus_valid_o) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
      end
      prev_wait  <= bus_valid_o && !bus_ready_i;
      prev_addr  <= bus_addr_o;
      prev_write <= bus_write_o;
      prev_wdata <= bus_wdata_o;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_model();
    @(negedge clk_i); model_clr = 1'b1;
    @(negedge clk_i); model_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i); rst_ni = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    clear_model();
  endtask

  // Drives one job and returns the cycle (edge 0 = accept) at which resp_valid_o is first seen.
  task automatic run_job(input logic [127:0] k, input logic [127:0] d,
                         output int n, output logic [127:0] dout, output logic [1:0] err);
    int g;
    n = 0; dout = '0; err = 2'b11;
    @(negedge clk_i);
    job_valid_i = 1'b1; job_key_i = k; job_din_i = d;
    g = 0;
    while (!job_ready_o && g < 100) begin @(negedge clk_i); g++; end
    if (!job_ready_o) begin
      n_assert++; n_fail++;
      $display("FAIL job_accept: job_ready_o=%0b required 1", job_ready_o);
      job_valid_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    job_valid_i = 1'b0;
    n = 1;
    while (!resp_valid_o && n < 3000) begin @(negedge clk_i); n++; end
    if (!resp_valid_o) begin
      n_assert++; n_fail++;
      $display("FAIL resp_wait: resp_valid_o=0 after %0d cycles, required 1", n);
      return;
    end
    dout = resp_dout_o; err = resp_err_o;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
  endtask

  function automatic int count_range(input logic [31:0] lo, input logic [31:0] hi, input logic wr);
    int c = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_addr[i] >= lo && log_addr[i] <= hi && log_wr[i] == wr) c++;
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_assert++; if (bus_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_bus_valid: got %0b required 0", bus_valid_o); end
    n_assert++; if (job_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_job_ready: got %0b required 0", job_ready_o); end
    n_assert++; if (resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %0b required 0", resp_valid_o); end
    n_assert++; if (resp_dout_o !== 128'h0) begin n_fail++; $display("FAIL rst_dout: got %h required 0", resp_dout_o); end
    n_assert++; if (resp_err_o !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b required 00", resp_err_o); end
    n_assert++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy_o); end
    @(negedge clk_i); rst_ni = 1'b1;
    clear_model();
    n_assert++; if (job_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_job_ready: got %0b required 1", job_ready_o); end
    n_assert++; if (bus_wstrb_o !== 4'hF) begin n_fail++; $display("FAIL wstrb: got %h required f", bus_wstrb_o); end
  endtask

  task automatic test_basic();
    logic [127:0] k = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    logic [127:0] d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    logic [31:0]  ea [14];
    logic         ew [14];
    logic [31:0]  ed [14];
    logic [127:0] dout;
    logic [1:0]   err;
    int n;
    wait_cfg = 0; done_on_poll = 1; err_en = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ea[i]    = BASE + 32'h10 + 32'(4*i); ew[i]    = 1'b1; ed[i]    = k[32*i +: 32];
      ea[4+i]  = BASE + 32'h20 + 32'(4*i); ew[4+i]  = 1'b1; ed[4+i]  = d[32*i +: 32];
      ea[10+i] = BASE + 32'h30 + 32'(4*i); ew[10+i] = 1'b0; ed[10+i] = 32'h0;
    end
    ea[8] = A_CTRL; ew[8] = 1'b1; ed[8] = 32'h1;
    ea[9] = A_STAT; ew[9] = 1'b0; ed[9] = 32'h0;
    run_job(k, d, n, dout, err);
    n_assert++; if (n != 15) begin n_fail++; $display("FAIL basic_latency: got %0d required 15", n); end
    n_assert++; if (dout !== exp_res(k, d)) begin n_fail++; $display("FAIL basic_dout: got %h required %h", dout, exp_res(k, d)); end
    n_assert++; if (err !== 2'b00) begin n_fail++; $display("FAIL basic_err: got %b required 00", err); end
    n_assert++;
    if (log_addr.size() != 14) begin
      n_fail++; $display("FAIL basic_beat_count: got %0d required 14", log_addr.size());
    end else begin
      for (int i = 0; i < 14; i++) begin
        n_assert++;
        if (log_addr[i] !== ea[i] || log_wr[i] !== ew[i] || (ew[i] && log_wd[i] !== ed[i])) begin
          n_fail++;
          $display("FAIL basic_beat%0d: got addr=%h wr=%0b data=%h required addr=%h wr=%0b data=%h",
                   i, log_addr[i], log_wr[i], log_wd[i], ea[i], ew[i], ed[i]);
        end
      end
    end
    n_assert++; if (job_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got ready=%0b busy=%0b required 1/0", job_ready_o, busy_o); end
  endtask

  task automatic test_wait_states();
    logic [127:0] k = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    logic [127:0] d = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    logic [127:0] dout;
    logic [1:0]   err;
    int n, polls;
    wait_cfg = 3; done_on_poll = 5; err_en = 1'b0;
    do_reset();
    run_job(k, d, n, dout, err);
    polls = count_range(A_STAT, A_STAT, 1'b0);
    n_assert++; if (stab_err != 0) begin n_fail++; $display("FAIL wait_stability: got %0d changes required 0", stab_err); end
    n_assert++; if (polls != 5) begin n_fail++; $display("FAIL wait_polls: got %0d required 5", polls); end
    n_assert++; if (n != 73) begin n_fail++; $display("FAIL wait_latency: got %0d required 73", n); end
    n_assert++; if (dout !== exp_res(k, d)) begin n_fail++; $display("FAIL wait_dout: got %h required %h", dout, exp_res(k, d)); end
    n_assert++; if (err !== 2'b00) begin n_fail++; $display("FAIL wait_err: got %b required 00", err); end
    wait_cfg = 0;
  endtask

  task automatic test_bus_error();
    logic [127:0] dout;
    logic [1:0]   err;
    int n, starts;
    wait_cfg = 0; done_on_poll = 1; err_en = 1'b1; err_addr = BASE + 32'h28;
    do_reset();
    run_job(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 128'h1, n, dout, err);
    starts = count_range(A_CTRL, A_CTRL, 1'b1);
    n_assert++; if (starts != 0) begin n_fail++; $display("FAIL berr_no_start: got %0d start writes required 0", starts); end
    n_assert++; if (log_addr.size() != 7) begin n_fail++; $display("FAIL berr_beats: got %0d required 7", log_addr.size()); end
    n_assert++; if (n != 8) begin n_fail++; $display("FAIL berr_latency: got %0d required 8", n); end
    n_assert++; if (err !== 2'b01) begin n_fail++; $display("FAIL berr_err: got %b required 01", err); end
    n_assert++; if (dout !== 128'h0) begin n_fail++; $display("FAIL berr_dout: got %h required 0", dout); end
    n_assert++; if (job_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL berr_idle: got ready=%0b busy=%0b required 1/0", job_ready_o, busy_o); end
    err_en = 1'b0;
  endtask

  task automatic test_timeout();
    int g, polls;
    do_reset();
    @(negedge clk_i); t_job_valid = 1'b1;
    @(negedge clk_i); t_job_valid = 1'b0;
    polls = 0; g = 0;
    while (!t_resp_valid && g < 200) begin
      if (t_bus_valid && !t_bus_write && t_bus_addr == A_STAT) polls++;
      @(negedge clk_i); g++;
    end
    n_assert++; if (!t_resp_valid) begin n_fail++; $display("FAIL tmo_resp: resp_valid=0 after %0d cycles required 1", g); end
    n_assert++; if (polls != 16) begin n_fail++; $display("FAIL tmo_poll_cycles: got %0d required 16", polls); end
    n_assert++; if (t_resp_err !== 2'b10) begin n_fail++; $display("FAIL tmo_err: got %b required 10", t_resp_err); end
    n_assert++; if (t_resp_dout !== 128'h0) begin n_fail++; $display("FAIL tmo_dout: got %h required 0", t_resp_dout); end
    t_resp_ready = 1'b1;
    @(negedge clk_i); t_resp_ready = 1'b0;
    n_assert++; if (t_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got busy=%0b required 0", t_busy); end
  endtask

  task automatic test_reset_in_poll();
    logic [127:0] k = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    logic [127:0] d = 128'h00000001_00000002_00000003_00000004;
    logic [127:0] dout;
    logic [1:0]   err;
    int g, n;
    wait_cfg = 0; done_on_poll = 0; err_en = 1'b0;
    do_reset();
    @(negedge clk_i); job_valid_i = 1'b1; job_key_i = k; job_din_i = d;
    @(negedge clk_i); job_valid_i = 1'b0;
    g = 0;
    while (!(bus_valid_o && bus_addr_o == A_STAT) && g < 100) begin @(negedge clk_i); g++; end
    n_assert++; if (!(bus_valid_o && bus_addr_o == A_STAT)) begin n_fail++; $display("FAIL rip_reach_poll: got addr=%h required %h", bus_addr_o, A_STAT); end
    #1 rst_ni = 1'b0;
    #1;
    n_assert++; if (bus_valid_o !== 1'b0) begin n_fail++; $display("FAIL rip_bus_valid: got %0b required 0", bus_valid_o); end
    n_assert++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rip_busy: got %0b required 0", busy_o); end
    @(negedge clk_i); rst_ni = 1'b1;
    done_on_poll = 1;
    clear_model();
    run_job(k, d, n, dout, err);
    n_assert++; if (n != 15) begin n_fail++; $display("FAIL rip_latency: got %0d required 15", n); end
    n_assert++; if (dout !== exp_res(k, d)) begin n_fail++; $display("FAIL rip_dout: got %h required %h", dout, exp_res(k, d)); end
    n_assert++; if (err !== 2'b00) begin n_fail++; $display("FAIL rip_err: got %b required 00", err); end
  endtask

`ifdef AES2_SEQ_KEY_CACHE_EN
  task automatic test_key_cache();
    logic [127:0] k1 = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
    logic [127:0] k2 = 128'h603DEB10_15CA71BE_2B73AEF0_857D7781;
    logic [127:0] d  = 128'h6BC1BEE2_2E409F96_E93D7E11_7393172A;
    logic [127:0] d2 = 128'hAE2D8A57_1E03AC9C_9EB76FAC_45AF8E51;
    logic [127:0] dout;
    logic [1:0]   err;
    int n, kw;
    wait_cfg = 0; done_on_poll = 1; err_en = 1'b0;
    do_reset();
    run_job(k1, d, n, dout, err);
    n_assert++; if (n != 15) begin n_fail++; $display("FAIL kc_first_latency: got %0d required 15", n); end
    clear_model();
    run_job(k1, d2, n, dout, err);
    kw = count_range(BASE + 32'h10, BASE + 32'h1C, 1'b1);
    n_assert++; if (kw != 0) begin n_fail++; $display("FAIL kc_hit_key_writes: got %0d required 0", kw); end
    n_assert++; if (n != 11) begin n_fail++; $display("FAIL kc_hit_latency: got %0d required 11", n); end
    n_assert++; if (dout !== exp_res(k1, d2)) begin n_fail++; $display("FAIL kc_hit_dout: got %h required %h", dout, exp_res(k1, d2)); end
    clear_model();
    run_job(k2, d, n, dout, err);
    kw = count_range(BASE + 32'h10, BASE + 32'h1C, 1'b1);
    n_assert++; if (kw != 4) begin n_fail++; $display("FAIL kc_miss_key_writes: got %0d required 4", kw); end
    n_assert++; if (n != 15) begin n_fail++; $display("FAIL kc_miss_latency: got %0d required 15", n); end
    n_assert++; if (dout !== exp_res(k2, d)) begin n_fail++; $display("FAIL kc_miss_dout: got %h required %h", dout, exp_res(k2, d)); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_bus_error();
    test_timeout();
    test_reset_in_poll();
`ifdef AES2_SEQ_KEY_CACHE_EN
    test_key_cache();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes2_reg_sequencer.md
Name: aes2_reg_sequencer

Overview:
Bus-master controller that runs one AES block operation end to end on the AES2 register-bus slave. It accepts a job (128-bit key plus 128-bit input block) over a valid/ready port and performs every step of the operation: writes the key and input, writes the start command, polls status, and reads back the 128-bit result. It sits between an accelerator client, such as a DMA or secure-boot engine, and the AES2 peripheral port, so the CPU does not have to sequence the peripheral by software.

Parameters:
- BASE_ADDR, default ariane_soc::AES2Base: base address of the AES2 register window.
- TIMEOUT_CYC, default 1024: maximum number of cycles spent in POLL before the job is aborted.
- ADDR_WIDTH, default 32: bus address width.
- DATA_WIDTH, default 32: bus data width. Only 32 is supported.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- job_valid_i  in  1  job request
- job_ready_o  out  1  job accepted when valid && ready
- job_key_i  in  128  key; bits [31:0] form word 0
- job_din_i  in  128  input block; bits [31:0] form word 0
- resp_valid_o  out  1  result available
- resp_ready_i  in  1  result consumed when valid && ready
- resp_dout_o  out  128  result block
- resp_err_o  out  2  00 ok, 01 bus error, 10 timeout
- busy_o  out  1  high in every state except IDLE
- bus_addr_o  out  ADDR_WIDTH  master address
- bus_write_o  out  1  1 for a write, 0 for a read
- bus_wdata_o  out  32  write data
- bus_wstrb_o  out  4  fixed at 4'hF
- bus_valid_o  out  1  request
- bus_ready_i  in  1  slave completes the beat
- bus_rdata_i  in  32  read data
- bus_error_i  in  1  slave error; qualified by valid && ready

Behaviour:
- Register map, as byte offsets from BASE_ADDR:
  - CTRL 0x00: bit0 is start.
  - STATUS 0x04: bit0 is done.
  - KEY0-3 at 0x10-0x1C.
  - DIN0-3 at 0x20-0x2C.
  - DOUT0-3 at 0x30-0x3C.
- Reset: async, active-low.
  - State returns to IDLE and all outputs go low or zero: bus_valid_o=0, job_ready_o=0, resp_valid_o=0, resp_dout_o=0, resp_err_o=0, busy_o=0.
  - Reset mid-operation abandons the job with no further bus beats. An in-flight beat is dropped because valid falls.
- job_ready_o equals (state==IDLE). On accept, key and din are latched into internal 128-bit registers.
- FSM states and transitions:
  - IDLE -> WR_KEY on accept.
  - WR_KEY -> WR_DIN after 4 beats.
  - WR_DIN -> WR_START after 4 beats.
  - WR_START (writes 0x1 to CTRL) -> POLL.
  - POLL (reads STATUS) -> RD_DOUT when rdata[0]=1; otherwise it re-polls on the next cycle.
  - RD_DOUT -> RESP after 4 beats.
  - RESP -> IDLE when resp_ready_i is high.
- Bus beats:
  - bus_valid_o is asserted with addr, write and wdata stable until the cycle bus_ready_i=1.
  - Back-to-back beats are allowed, with no idle cycle between them.
  - A 2-bit word counter indexes words 0..3 at ascending addresses. It wraps to 0 on each state change.
- bus_error_i on a completed beat in any state: go to RESP immediately with err=01 and dout=0.
- Timeout:
  - A cycle counter is cleared on entry to POLL and increments every cycle spent in POLL.
  - Reaching TIMEOUT_CYC while done is still 0 sends the FSM to RESP with err=10 and dout=0.
  - A done beat in the same cycle as timeout wins: the FSM goes to RD_DOUT.
- RESP: resp_valid_o=1, with dout and err held stable until the handshake.
- Latency with bus_ready_i tied high and done on the first poll:
  - Accept on edge 0; key beats in cycles 1-4, din 5-8, start 9, poll 10, reads 11-14.
  - resp_valid_o is high from cycle 15.
- A new job cannot be accepted in the same cycle as the resp handshake. IDLE is entered first.

Optional Feature:
AES2_SEQ_KEY_CACHE_EN
- Defined:
  - A 128-bit last-key register plus a key_valid bit are kept. Reset clears key_valid.
  - If a job's key equals the cached key and key_valid=1, WR_KEY is skipped and the FSM goes IDLE -> WR_DIN. Latency drops by 4 cycles.
  - The cache is updated only on an err=00 completion.
  - key_valid is cleared on any error.
- Undefined: the key is always written, and no extra flops exist.

Decomposition:
- Package aes2_seq_pkg holds:
  - the state enum;
  - the register offset localparams (CTRL, STATUS, KEY, DIN, DOUT);
  - the err code constants (ERR_OK, ERR_BUS, ERR_TMO).
- Sub-module aes2_seq_bus_master is a single-beat master: it holds the request until ready and returns a done/rdata/err pulse. The FSM stays in the top module.

Test Plan:
1. Ready tied high, slave model returns done on the first poll.
   - Job: key=0x000102..0F, din=0x00112233..FF.
   - Required: writes in order to 0x10-0x1C, 0x20-0x2C, then 0x1 to 0x00; one read of 0x04; reads of 0x30-0x3C.
   - resp_valid_o at cycle 15, dout equals the model result, err=00.
2. Slave inserts 3 wait cycles per beat and returns done on the 5th poll.
   - Required: address and data stable during waits, exactly 5 STATUS reads, correct dout.
3. bus_error_i on the DIN2 write.
   - Required: no start write, resp with err=01 and dout=0, then back to IDLE.
4. Done never set, TIMEOUT_CYC=16.
   - Required: exactly 16 cycles in POLL, then err=10.
5. Assert rst_ni low during POLL.
   - Required: bus_valid_o=0 immediately (async), busy_o=0; the next job then runs cleanly.
6. With AES2_SEQ_KEY_CACHE_EN, two jobs with the same key.
   - Required: the second job issues no key writes and resp_valid_o arrives at cycle 11.
   - A third job with a different key writes all 4 KEY words.
